// File: rtl/dec_nbload_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : dec_nbload_scoreboard
// Brief    : Tracks in-flight non-blocking loads, raises decode hazards and
//            issues a registered register-file writeback on late data return.
// Revision : 1.0
// ============================================================================
module dec_nbload_scoreboard #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 2
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             lsu_nonblock_load_valid_dc3,
  input  logic [TAG_W-1:0] lsu_nonblock_load_tag_dc3,
  input  logic [4:0]       lsu_nonblock_load_rd_dc3,
  input  logic             lsu_nonblock_load_inv_dc5,
  input  logic [TAG_W-1:0] lsu_nonblock_load_inv_tag_dc5,
  input  logic             lsu_nonblock_load_data_valid,
  input  logic [TAG_W-1:0] lsu_nonblock_load_data_tag,
  input  logic [31:0]      lsu_nonblock_load_data,
  input  logic             dec_wen_wb,
  input  logic [4:0]       dec_waddr_wb,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
  output logic             nb_rs1_stall,
  output logic             nb_rs2_stall,
  output logic             nb_rd_stall,
  output logic             nb_full,
  output logic             nb_wen,
  output logic [4:0]       nb_waddr,
  output logic [31:0]      nb_wdata,
  output logic             nb_err
);

  localparam logic [4:0] c_x0 = 5'd0;

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [NUM_ENTRIES-1:0] r_wb;
  logic [TAG_W-1:0]       r_tag [NUM_ENTRIES];
  logic [4:0]             r_rd  [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] w_tag_live;
  logic [NUM_ENTRIES-1:0] w_inv_hit;
  logic [NUM_ENTRIES-1:0] w_data_hit;
  logic [NUM_ENTRIES-1:0] w_wb_clr;
  logic [NUM_ENTRIES-1:0] w_live_rd;
  logic [NUM_ENTRIES-1:0] w_rs1_hit;
  logic [NUM_ENTRIES-1:0] w_rs2_hit;
  logic [NUM_ENTRIES-1:0] w_rd_hit;
  logic [NUM_ENTRIES-1:0] w_alloc_sel;

  logic        w_alloc_ok;
  logic        w_alloc_rej;
  logic        w_commit;
  logic        w_data_miss;
  logic        w_wb_fire;
  logic [4:0]  w_wb_rd;

  assign nb_full     = &r_valid;
  assign w_commit    = dec_wen_wb && (dec_waddr_wb != c_x0);
  assign w_alloc_ok  = lsu_nonblock_load_valid_dc3 && !nb_full && !(|w_tag_live);
  assign w_alloc_rej = lsu_nonblock_load_valid_dc3 && !w_alloc_ok;
  assign w_data_miss = lsu_nonblock_load_data_valid && !(|w_data_hit);

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      assign w_tag_live[gi] = r_valid[gi] && (r_tag[gi] == lsu_nonblock_load_tag_dc3);
      assign w_inv_hit[gi]  = lsu_nonblock_load_inv_dc5 && r_valid[gi] &&
                              (r_tag[gi] == lsu_nonblock_load_inv_tag_dc5);
      assign w_data_hit[gi] = lsu_nonblock_load_data_valid && r_valid[gi] &&
                              (r_tag[gi] == lsu_nonblock_load_data_tag);
      // A younger load or an in-order commit to the same rd owns the final value.
      assign w_wb_clr[gi]   = r_valid[gi] &&
                              ((w_alloc_ok && (r_rd[gi] == lsu_nonblock_load_rd_dc3)) ||
                               (w_commit && (r_rd[gi] == dec_waddr_wb)));
      assign w_live_rd[gi]  = r_valid[gi] && (r_rd[gi] != c_x0);
      assign w_rs1_hit[gi]  = w_live_rd[gi] && (r_rd[gi] == dec_rs1);
      assign w_rs2_hit[gi]  = w_live_rd[gi] && (r_rd[gi] == dec_rs2);
      assign w_rd_hit[gi]   = w_live_rd[gi] && (r_rd[gi] == dec_rd);
    end
  endgenerate

  assign nb_rs1_stall = |w_rs1_hit;
  assign nb_rs2_stall = |w_rs2_hit;
  assign nb_rd_stall  = |w_rd_hit;

  // Lowest-index free slot, judged on current-cycle valid bits only.
  always_comb begin
    logic w_found;
    w_found     = 1'b0;
    w_alloc_sel = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!r_valid[i] && !w_found) begin
        w_alloc_sel[i] = w_alloc_ok;
        w_found        = 1'b1;
      end
    end
  end

  always_comb begin
    w_wb_fire = 1'b0;
    w_wb_rd   = c_x0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_data_hit[i] && r_wb[i]) begin
        w_wb_fire = 1'b1;
        w_wb_rd   = w_wb_rd | r_rd[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_valid <= '0;
      r_wb    <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_rd[i]  <= c_x0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_alloc_sel[i]) begin
          r_valid[i] <= 1'b1;
          r_wb[i]    <= (lsu_nonblock_load_rd_dc3 != c_x0);
          r_tag[i]   <= lsu_nonblock_load_tag_dc3;
          r_rd[i]    <= lsu_nonblock_load_rd_dc3;
        end else begin
          if (w_data_hit[i] || w_inv_hit[i]) begin
            r_valid[i] <= 1'b0;
          end
          if (w_wb_clr[i]) begin
            r_wb[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      nb_wen   <= 1'b0;
      nb_waddr <= c_x0;
      nb_wdata <= '0;
      nb_err   <= 1'b0;
    end else begin
      nb_wen <= w_wb_fire;
      nb_err <= w_alloc_rej || w_data_miss;
      if (w_wb_fire) begin
        nb_waddr <= w_wb_rd;
        nb_wdata <= lsu_nonblock_load_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dec_nbload_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_nbload_scoreboard
// Brief    : Vector-table and scoreboard bench for dec_nbload_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_dec_nbload_scoreboard;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        av = 1'b0, iv = 1'b0, dv = 1'b0, cw = 1'b0;
  logic [1:0]  atag = '0, itag = '0, dtag = '0;
  logic [4:0]  ard = '0, cwa = '0, rs1 = '0, rs2 = '0, drd = '0;
  logic [31:0] data = '0;
  logic        nb_rs1_stall, nb_rs2_stall, nb_rd_stall, nb_full, nb_wen, nb_err;
  logic [4:0]  nb_waddr;
  logic [31:0] nb_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic av; logic [1:0] atag; logic [4:0] ard;
    logic iv; logic [1:0] itag;
    logic dv; logic [1:0] dtag; logic [31:0] data;
    logic cw; logic [4:0] cwa;
    logic [4:0] rs1, rs2, rd;
    logic e_rs1, e_rs2, e_rd, e_full;
    logic e_wen; logic [4:0] e_waddr; logic e_err;
  } vec_t;

  vec_t        vecs[$];
  logic [36:0] sb[$];

  dec_nbload_scoreboard #(.NUM_ENTRIES(4), .TAG_W(2)) dut (
    .clk                           (clk),
    .rst_l                         (rst_l),
    .lsu_nonblock_load_valid_dc3   (av),
    .lsu_nonblock_load_tag_dc3     (atag),
    .lsu_nonblock_load_rd_dc3      (ard),
    .lsu_nonblock_load_inv_dc5     (iv),
    .lsu_nonblock_load_inv_tag_dc5 (itag),
    .lsu_nonblock_load_data_valid  (dv),
    .lsu_nonblock_load_data_tag    (dtag),
    .lsu_nonblock_load_data        (data),
    .dec_wen_wb                    (cw),
    .dec_waddr_wb                  (cwa),
    .dec_rs1                       (rs1),
    .dec_rs2                       (rs2),
    .dec_rd                        (drd),
    .nb_rs1_stall                  (nb_rs1_stall),
    .nb_rs2_stall                  (nb_rs2_stall),
    .nb_rd_stall                   (nb_rd_stall),
    .nb_full                       (nb_full),
    .nb_wen                        (nb_wen),
    .nb_waddr                      (nb_waddr),
    .nb_wdata                      (nb_wdata),
    .nb_err                        (nb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic add(input logic a, input logic [1:0] at, input logic [4:0] ar,
                     input logic i, input logic [1:0] it,
                     input logic d, input logic [1:0] dt, input logic [31:0] dd,
                     input logic c, input logic [4:0] ca,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rr,
                     input logic s1, input logic s2, input logic sr, input logic f,
                     input logic w, input logic [4:0] wa, input logic e);
    vec_t v;
    v.av = a; v.atag = at; v.ard = ar; v.iv = i; v.itag = it;
    v.dv = d; v.dtag = dt; v.data = dd; v.cw = c; v.cwa = ca;
    v.rs1 = r1; v.rs2 = r2; v.rd = rr;
    v.e_rs1 = s1; v.e_rs2 = s2; v.e_rd = sr; v.e_full = f;
    v.e_wen = w; v.e_waddr = wa; v.e_err = e;
    vecs.push_back(v);
  endtask

  task automatic check_write(input string name);
    logic [36:0] exp;
    if (nb_wen) begin
      if (sb.size() == 0) begin
        chk({name, "_unexpected_wen"}, 32'(nb_wen), 32'd0);
      end else begin
        exp = sb.pop_front();
        chk({name, "_waddr"}, 32'(nb_waddr), 32'(exp[36:32]));
        chk({name, "_wdata"}, nb_wdata, exp[31:0]);
      end
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    string n;
    n = $sformatf("v%0d", idx);
    @(negedge clk);
    av = v.av; atag = v.atag; ard = v.ard; iv = v.iv; itag = v.itag;
    dv = v.dv; dtag = v.dtag; data = v.data; cw = v.cw; cwa = v.cwa;
    rs1 = v.rs1; rs2 = v.rs2; drd = v.rd;
    #1;
    chk({n, "_rs1_stall"}, 32'(nb_rs1_stall), 32'(v.e_rs1));
    chk({n, "_rs2_stall"}, 32'(nb_rs2_stall), 32'(v.e_rs2));
    chk({n, "_rd_stall"},  32'(nb_rd_stall),  32'(v.e_rd));
    chk({n, "_full"},      32'(nb_full),      32'(v.e_full));
    if (v.e_wen) sb.push_back({v.e_waddr, v.data});
    @(posedge clk);
    #1;
    chk({n, "_wen"}, 32'(nb_wen), 32'(v.e_wen));
    chk({n, "_err"}, 32'(nb_err), 32'(v.e_err));
    check_write(n);
  endtask

  initial begin
    //  av at ard  iv it  dv dt data          cw cwa  rs1 rs2 rd   s1 s2 sr f  w wa e
    // Single load, data return two cycles later
    add(1, 1, 5,   0, 0,  0, 0, 32'h0,         0, 0,   5,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  0, 0, 32'h0,         0, 0,   5,  0,  0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  1, 1, 32'hDEADBEEF,  0, 0,   5,  0,  0,  1, 0, 0, 0, 1, 5, 0);
    add(0, 0, 0,   0, 0,  0, 0, 32'h0,         0, 0,   5,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    // Fill, overflow, same-cycle free rejection, reuse
    add(1, 0, 1,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 2,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 3,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(1, 3, 4,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6,   0, 0,  0, 0, 32'h0,         0, 0,   1,  4,  3,  1, 1, 1, 1, 0, 0, 1);
    add(1, 2, 6,   0, 0,  1, 2, 32'h00000033,  0, 0,   0,  0,  0,  0, 0, 0, 1, 1, 3, 1);
    add(1, 2, 10,  0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0, 10,  0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 32'h00000010,  0, 0,   0,  0,  0,  0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0,   0, 0,  1, 1, 32'h00000011,  0, 0,   0,  0,  0,  0, 0, 0, 0, 1, 2, 0);
    add(0, 0, 0,   0, 0,  1, 3, 32'h00000013,  0, 0,   0,  0,  0,  0, 0, 0, 0, 1, 4, 0);
    add(0, 0, 0,   0, 0,  1, 2, 32'h00000012,  0, 0,   0,  0,  0,  0, 0, 0, 0, 1, 10, 0);
    // Younger load to the same rd supersedes the older
    add(1, 0, 7,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  7,  0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 7,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  7,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  1, 0, 32'h000000A0,  0, 0,   0,  0,  7,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  1, 1, 32'h000000A1,  0, 0,   0,  0,  7,  0, 0, 1, 0, 1, 7, 0);
    add(0, 0, 0,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  7,  0, 0, 0, 0, 0, 0, 0);
    // Commit write clears writeback; entry stays until data
    add(1, 3, 9,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  0, 0, 32'h0,         1, 9,   0,  0,  9,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  1, 3, 32'h000000B3,  0, 0,   0,  0,  9,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  9,  0, 0, 0, 0, 0, 0, 0);
    // x0 destination, unmatched cancel and unmatched data
    add(1, 2, 0,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  1, 2, 32'h00000022,  0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   1, 1,  0, 0, 32'h0,         0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  1, 1, 32'h00000055,  0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    // Cancel of a live load
    add(1, 1, 12,  0, 0,  0, 0, 32'h0,         0, 0,   0,  0, 12,  0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   1, 1,  0, 0, 32'h0,         0, 0,   0,  0, 12,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  0, 0, 32'h0,         0, 0,   0,  0, 12,  0, 0, 0, 0, 0, 0, 0);
    // Commit + alloc same rd; cancel + data same tag
    add(1, 0, 13,  0, 0,  0, 0, 32'h0,         0, 0,   0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 13,  0, 0,  0, 0, 32'h0,         1, 13, 13,  0,  0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   1, 1,  1, 1, 32'h000000C1,  0, 0,  13,  0,  0,  1, 0, 0, 0, 1, 13, 0);
    add(0, 0, 0,   0, 0,  1, 0, 32'h000000C0,  0, 0,  13,  0,  0,  1, 0, 0, 0, 0, 0, 0);
    // Two live entries ahead of the reset sequence
    add(1, 0, 20,  0, 0,  0, 0, 32'h0,         0, 0,  20, 21,  0,  0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 21,  0, 0,  0, 0, 32'h0,         0, 0,  20, 21,  0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,   0, 0,  0, 0, 32'h0,         0, 0,  20, 21,  0,  1, 1, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wen",   32'(nb_wen),   32'd0);
    chk("rst_waddr", 32'(nb_waddr), 32'd0);
    chk("rst_wdata", nb_wdata,      32'd0);
    chk("rst_err",   32'(nb_err),   32'd0);
    chk("rst_full",  32'(nb_full),  32'd0);
    chk("rst_stall", 32'({nb_rs1_stall, nb_rs2_stall, nb_rd_stall}), 32'd0);
    rst_l = 1'b1;

    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

    // Reset asserted mid-cycle while a writeback is pending
    @(negedge clk);
    av = 0; iv = 0; cw = 0; dv = 1; dtag = 2'd0; data = 32'h000000E0;
    rs1 = 5'd20; rs2 = 5'd21; drd = 5'd0;
    sb.push_back({5'd20, 32'h000000E0});
    @(posedge clk);
    #1;
    chk("pre_rst_wen", 32'(nb_wen), 32'd1);
    check_write("pre_rst");
    #2;
    rst_l = 1'b0;
    #1;
    chk("mid_rst_wen",   32'(nb_wen),       32'd0);
    chk("mid_rst_full",  32'(nb_full),      32'd0);
    chk("mid_rst_rs1",   32'(nb_rs1_stall), 32'd0);
    chk("mid_rst_rs2",   32'(nb_rs2_stall), 32'd0);
    dv = 0;
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_wen",   32'(nb_wen),  32'd0);
    chk("post_rst_stall", 32'({nb_rs1_stall, nb_rs2_stall, nb_rd_stall}), 32'd0);
    chk("post_rst_full",  32'(nb_full), 32'd0);

    // Tag 0 was discarded by reset, so it can be allocated again
    begin
      vec_t v;
      v = '{av:1, atag:0, ard:5, iv:0, itag:0, dv:0, dtag:0, data:0, cw:0, cwa:0,
            rs1:5, rs2:0, rd:0, e_rs1:0, e_rs2:0, e_rd:0, e_full:0,
            e_wen:0, e_waddr:0, e_err:0};
      apply(v, 100);
      v.av = 0; v.e_rs1 = 1;
      apply(v, 101);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dec_nbload_scoreboard.md
Name: dec_nbload_scoreboard

Overview:
- Tracks outstanding non-blocking loads between LSU issue and late data return.
- Holds one entry per in-flight load: {valid, wb, tag, rd}.
- Feeds decode with register-hazard stalls.
- On data return, produces a registered writeback to the integer register file.

Parameters:
NUM_ENTRIES, 4, number of tracked in-flight loads (matches RV_LSU_NUM_NBLOAD)
TAG_W, 2, width of LSU load tag (matches RV_LSU_NUM_NBLOAD_WIDTH)

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
lsu_nonblock_load_valid_dc3  in  1  allocate request
lsu_nonblock_load_tag_dc3  in  TAG_W  tag of allocating load
lsu_nonblock_load_rd_dc3  in  5  destination register of allocating load
lsu_nonblock_load_inv_dc5  in  1  cancel request
lsu_nonblock_load_inv_tag_dc5  in  TAG_W  tag to cancel
lsu_nonblock_load_data_valid  in  1  data return
lsu_nonblock_load_data_tag  in  TAG_W  tag of returned data
lsu_nonblock_load_data  in  32  returned load data
dec_wen_wb  in  1  in-order pipe register write at commit
dec_waddr_wb  in  5  address of that write
dec_rs1  in  5  decode source reg 1
dec_rs2  in  5  decode source reg 2
dec_rd  in  5  decode destination
nb_rs1_stall  out  1  rs1 hazard
nb_rs2_stall  out  1  rs2 hazard
nb_rd_stall  out  1  WAW hazard on dec_rd
nb_full  out  1  all entries valid
nb_wen  out  1  registered writeback enable
nb_waddr  out  5  writeback register
nb_wdata  out  32  writeback data
nb_err  out  1  one-cycle error pulse

Behaviour:
- Reset values:
  - All entry fields 0.
  - nb_wen = 0, nb_waddr = 0, nb_wdata = 0, nb_err = 0.
  - Combinational outputs evaluate to 0 with no valid entries.
- Allocate:
  - On valid_dc3 when not full and no valid entry holds the same tag, write the lowest-index free entry: valid=1, wb=(rd!=0), tag, rd.
  - The same edge clears wb on every older valid entry with equal rd (younger load supersedes).
- Allocate rejection:
  - Allocate while nb_full, or with a tag already live, is dropped.
  - nb_err pulses high the next cycle.
- Free selection: allocation sees free slots as of the current cycle. An entry freed this cycle is not reusable until the next cycle.
- Cancel: inv_dc5 clears valid of the tag-matching entry; no write. An unmatched cancel is ignored.
- Data return:
  - A match on a valid entry frees it at the edge.
  - If wb=1, the next cycle has nb_wen=1, nb_waddr=rd, nb_wdata=data. This is one-cycle latency, with nb_wen high for exactly one cycle.
  - If wb=0, the entry is freed silently.
  - Unmatched data return: no write; nb_err pulses next cycle.
- Commit write: dec_wen_wb with dec_waddr_wb!=0 clears wb of all valid entries with equal rd. Those entries stay valid until data or cancel.
- Simultaneous events in one cycle:
  - Allocate, cancel, data and commit all apply independently.
  - Cancel and data on the same tag: data wins (write occurs if wb=1).
  - Commit-clear and allocate on the same rd: the new entry keeps wb=1.
- Hazards (combinational, valid entries only, x0 never hazards):
  - nb_rs1_stall = any entry with rd==dec_rs1.
  - nb_rs2_stall = any entry with rd==dec_rs2.
  - nb_rd_stall = any entry with rd==dec_rd.
  - An entry being freed this cycle still stalls this cycle.
- nb_full = AND of all valid bits.
- Reset mid-operation: all entries are discarded immediately; any pending nb_wen is suppressed asynchronously.

Test Plan:
1. Alloc tag=1 rd=5; data tag=1 value 0xDEADBEEF two cycles later -> next cycle nb_wen=1, nb_waddr=5, nb_wdata=0xDEADBEEF; nb_rs1_stall=1 with rs1=5 until the data cycle, then 0.
2. Alloc tags 0..3 (rd 1..4) -> nb_full=1. Fifth alloc tag=0 -> dropped, nb_err pulse. Data tag=2 frees slot 2; alloc in the same cycle is rejected; alloc the next cycle lands in slot 2.
3. Alloc tag=0 rd=7, then tag=1 rd=7; return tag=0 then tag=1 -> only one nb_wen, for tag=1 data.
4. Alloc tag=3 rd=9; dec_wen_wb waddr=9; data tag=3 -> no nb_wen; entry freed, nb_rd_stall drops with dec_rd=9.
5. Alloc tag=2 rd=0 -> no stall for rs1=0; data tag=2 -> no nb_wen. Cancel tag=1 (not live) -> no effect; data tag=1 unmatched -> nb_err pulse.
6. Two live entries plus data valid, then rst_l asserted low mid-cycle -> nb_wen=0 immediately, nb_full=0, all stalls 0 after release.
